// File: rtl/rst_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared types and helpers for the reset sequencer (rst_seq_ctrl).
//
//   Contents:
//     rst_seq_state_e : sequencer FSM state encoding
//     LOCK_LOSS_W     : width of the lock-loss event counter
//     cnt_width()     : bit width needed to hold a count of 0..max_val
//     sat_inc_loss()  : saturating increment for the lock-loss counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        WAIT_ACK  = 3'd3,
        GAP       = 3'd4,
        RUN       = 3'd5
    } rst_seq_state_e;

    localparam int LOCK_LOSS_W = 8;

    // Width of a counter that must represent 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    // Lock-loss events saturate instead of wrapping so that a flapping PLL
    // never makes the counter look healthy again.
    function automatic logic [LOCK_LOSS_W-1:0] sat_inc_loss(
        input logic [LOCK_LOSS_W-1:0] val
    );
        if (val == {LOCK_LOSS_W{1'b1}}) begin
            return val;
        end
        return val + LOCK_LOSS_W'(1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for level signals crossing into clk.
//   Output lags the input by two clk edges. Both flops reset to 0.
//
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset
//     d_i   : asynchronous input (WIDTH bits, each bit treated independently)
//     q_o   : synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//   Sequences reset release to downstream domains once the PLL has been
//   stably locked: stage 0 (SDRAM controller) first, then stage 1 (camera
//   capture), then stage 2 (frame-diff / VGA), and so on up to NUM_STAGES.
//   A stage may be made to wait for the previous stage's init-done ack.
//   Any loss of lock after the first release re-asserts every stage reset,
//   bumps a saturating lock-loss counter and restarts the sequence.
//
//   Optional feature (compile-time macro RST_SEQ_TIMEOUT_EN):
//     defined   : an ack wait longer than TIMEOUT_CYC cycles sets the sticky
//                 ack_timeout flag, re-asserts all stage resets and retries.
//     undefined : ack waits are unbounded and ack_timeout is tied to 0.
//
//   Ports:
//     clk           : system clock
//     rst_n         : asynchronous active-low reset
//     pll_locked    : PLL lock, asynchronous to clk (synchronized here)
//     stage_ack     : per-stage init-done, clk domain, level
//     stage_rst_n   : per-stage active-low reset, registered, thermometer code
//     seq_done      : all stages released
//     lock_loss_cnt : lock losses since rst_n, saturating at 255
//     ack_timeout   : sticky ack-wait timeout flag
// -----------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int                    NUM_STAGES  = 3,
    parameter int                    STABLE_CYC  = 1024,
    parameter int                    STAGE_GAP   = 16,
    parameter logic [NUM_STAGES-1:0] ACK_MASK    = NUM_STAGES'(1),
    parameter int                    TIMEOUT_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic [NUM_STAGES-1:0]  stage_ack,
    output logic [NUM_STAGES-1:0]  stage_rst_n,
    output logic                   seq_done,
    output logic [LOCK_LOSS_W-1:0] lock_loss_cnt,
    output logic                   ack_timeout
);

    // One counter is shared by STABLE, GAP and (optionally) WAIT_ACK, so it
    // is sized for the largest of the three limits.
    localparam int CNT_MAX_SG = (STABLE_CYC > STAGE_GAP) ? STABLE_CYC : STAGE_GAP;
    localparam int CNT_MAX    = (CNT_MAX_SG > TIMEOUT_CYC) ? CNT_MAX_SG : TIMEOUT_CYC;
    localparam int CNT_W      = cnt_width(CNT_MAX);
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

    // -------------------------------------------------------------------------
    // Lock synchronizer
    // -------------------------------------------------------------------------
    logic lk_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (lk_s)
    );

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    rst_seq_state_e         state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
    logic                   seq_done_q,  seq_done_d;
    logic [LOCK_LOSS_W-1:0] loss_cnt_q,  loss_cnt_d;
`ifdef RST_SEQ_TIMEOUT_EN
    logic                   timeout_q,   timeout_d;
`endif

    // States in which at least one stage has been (or is being) released;
    // losing lock here is a real lock-loss event.
    logic released_state;
    assign released_state = (state_q == RELEASE) || (state_q == WAIT_ACK) ||
                            (state_q == GAP)     || (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        seq_done_d  = 1'b0;
        loss_cnt_d  = loss_cnt_q;
`ifdef RST_SEQ_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif

        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                idx_d = '0;
                if (lk_s) begin
                    state_d = STABLE;
                end
            end

            STABLE: begin
                if (!lk_s) begin
                    // Nothing released yet: just restart the stability count.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                stage_rst_d[idx_q] = 1'b1;
                cnt_d              = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = RUN;
                end else if (ACK_MASK[idx_q]) begin
                    state_d = WAIT_ACK;
                end else begin
                    state_d = GAP;
                end
            end

            WAIT_ACK: begin
                // Only the ack of the most recently released stage matters.
                if (stage_ack[idx_q]) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d   = 1'b1;
                    stage_rst_d = '0;
                    state_d     = WAIT_LOCK;
                    cnt_d       = '0;
                    idx_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                seq_done_d = 1'b1;
            end

            default: begin
                state_d     = WAIT_LOCK;
                cnt_d       = '0;
                idx_d       = '0;
                stage_rst_d = '0;
            end
        endcase

        // Lock loss overrides whatever the state logic decided above.
        if (!lk_s && released_state) begin
            state_d     = WAIT_LOCK;
            cnt_d       = '0;
            idx_d       = '0;
            stage_rst_d = '0;
            seq_done_d  = 1'b0;
            loss_cnt_d  = sat_inc_loss(loss_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '0;
            seq_done_q  <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            seq_done_q  <= seq_done_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign ack_timeout = timeout_q;
`else
    assign ack_timeout = 1'b0;
`endif

    assign stage_rst_n   = stage_rst_q;
    assign seq_done      = seq_done_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//   Scoreboard bench for rst_seq_ctrl. Each stimulus step pushes the output
//   changes it should cause (edge number + full output word) into a queue; a
//   negedge monitor pops one entry per observed output change.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

    localparam int NS = 3;
    localparam int SC = 8;
    localparam int SG = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_rst_n;
    logic          seq_done;
    logic [7:0]    lock_loss_cnt;
    logic          ack_timeout;

    rst_seq_ctrl #(
        .NUM_STAGES  (NS),
        .STABLE_CYC  (SC),
        .STAGE_GAP   (SG),
        .ACK_MASK    (3'b001),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .stage_ack     (stage_ack),
        .stage_rst_n   (stage_rst_n),
        .seq_done      (seq_done),
        .lock_loss_cnt (lock_loss_cnt),
        .ack_timeout   (ack_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    typedef struct {
        string       tag;
        int          cyc;
        logic [12:0] val;
    } evt_t;

    evt_t sb_q[$];

    task automatic push_evt(input string tag, input int c, input logic [2:0] st,
                            input logic dn, input logic to, input logic [7:0] ll);
        evt_t e;
        e.tag = tag;
        e.cyc = c;
        e.val = {st, dn, to, ll};
        sb_q.push_back(e);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the output word must match the next expected event.
    logic        mon_en = 1'b0;
    logic [12:0] prev_val = '0;
    always @(negedge clk) begin
        logic [12:0] cur;
        evt_t e;
        cur = {stage_rst_n, seq_done, ack_timeout, lock_loss_cnt};
        if (mon_en) begin
            check("thermo", ((({1'b0, stage_rst_n} + 4'd1) & {1'b0, stage_rst_n}) == 4'd0), 1'b1);
            if (cur != prev_val) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_change", cur, prev_val);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_cyc"}, cyc, e.cyc);
                    check(e.tag, cur, e.val);
                end
            end
        end
        prev_val = cur;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, s0, s1, s2, dn, d, r, x;
        logic [7:0] llc;
        logic       tmo;

        // Reset held while the PLL already reports lock.
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        stage_ack  = '0;
        tmo        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stage", stage_rst_n, 3'b000);
        check("rst_done", seq_done, 1'b0);
        check("rst_llc", lock_loss_cnt, 8'd0);
        check("rst_tmo", ack_timeout, 1'b0);

        // Bring-up: stage 0 at cycle 11, ack at cycle 20, stage 1 at 26.
        r     = cyc;
        rst_n = 1'b1;
        mon_en = 1'b1;
        llc   = 8'd0;
        a  = r + 1;
        s0 = a + 3 + SC;
        push_evt("s0_boot", s0, 3'b001, 1'b0, tmo, llc);
        x  = r + 21;
        s1 = x + SG + 2;
        s2 = s1 + SG + 1;
        dn = s2 + 1;
        push_evt("s1_boot", s1, 3'b011, 1'b0, tmo, llc);
        push_evt("s2_boot", s2, 3'b111, 1'b0, tmo, llc);
        push_evt("done_boot", dn, 3'b111, 1'b1, tmo, llc);
        stage_ack = 3'b110;   // unreleased-stage acks must not matter
        to_cyc(x);
        stage_ack = 3'b001;
        to_cyc(x + 1);
        stage_ack = 3'b000;
        to_cyc(dn + 2);

        // Lock loss in RUN, then re-lock with ack already high.
        d = cyc;
        pll_locked = 1'b0;
        llc = 8'd1;
        push_evt("loss_run", d + 3, 3'b000, 1'b0, tmo, llc);
        to_cyc(d + 5);
        pll_locked = 1'b1;
        stage_ack  = 3'b001;
        a  = d + 6;
        s0 = a + 3 + SC;
        s1 = s0 + SG + 2;
        s2 = s1 + SG + 1;
        dn = s2 + 1;
        push_evt("s0_relock", s0, 3'b001, 1'b0, tmo, llc);
        push_evt("s1_relock", s1, 3'b011, 1'b0, tmo, llc);
        push_evt("s2_relock", s2, 3'b111, 1'b0, tmo, llc);
        push_evt("done_relock", dn, 3'b111, 1'b1, tmo, llc);
        to_cyc(dn + 2);

        // Lose lock, re-lock, then glitch lock for 5 cycles inside STABLE.
        d = cyc;
        pll_locked = 1'b0;
        llc = 8'd2;
        push_evt("loss_run2", d + 3, 3'b000, 1'b0, tmo, llc);
        to_cyc(d + 5);
        pll_locked = 1'b1;
        to_cyc(d + 12);
        pll_locked = 1'b0;
        to_cyc(d + 17);
        check("glitch_llc", lock_loss_cnt, 8'd2);
        check("glitch_stage", stage_rst_n, 3'b000);
        pll_locked = 1'b1;
        a  = d + 18;
        s0 = a + 3 + SC;
        s1 = s0 + SG + 2;
        s2 = s1 + SG + 1;
        dn = s2 + 1;
        push_evt("s0_glitch", s0, 3'b001, 1'b0, tmo, llc);
        push_evt("s1_glitch", s1, 3'b011, 1'b0, tmo, llc);
        push_evt("s2_glitch", s2, 3'b111, 1'b0, tmo, llc);
        push_evt("done_glitch", dn, 3'b111, 1'b1, tmo, llc);
        to_cyc(dn + 2);

        // 300 lock losses, each right after stage 0 release.
        d = cyc;
        pll_locked = 1'b0;
        stage_ack  = 3'b000;
        llc = 8'd3;
        push_evt("loss_run3", d + 3, 3'b000, 1'b0, tmo, llc);
        to_cyc(d + 3);
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            a  = cyc + 1;
            s0 = a + 3 + SC;
            push_evt("s0_loop", s0, 3'b001, 1'b0, tmo, llc);
            to_cyc(s0);
            pll_locked = 1'b0;
            if (llc != 8'd255) llc = llc + 8'd1;
            push_evt("loss_loop", s0 + 3, 3'b000, 1'b0, tmo, llc);
            to_cyc(s0 + 3);
        end
        check("llc_sat", lock_loss_cnt, 8'd255);

        // Ack never arrives for stage 0.
        pll_locked = 1'b1;
        a  = cyc + 1;
        s0 = a + 3 + SC;
        push_evt("s0_noack", s0, 3'b001, 1'b0, tmo, llc);
`ifdef RST_SEQ_TIMEOUT_EN
        tmo = 1'b1;
        push_evt("timeout", s0 + TO, 3'b000, 1'b0, tmo, llc);
        s0 = s0 + TO + 2 + SC;
        push_evt("s0_retry", s0, 3'b001, 1'b0, tmo, llc);
        to_cyc(s0 + 1);
`else
        to_cyc(s0 + TO + 20);
        check("noto_stage", stage_rst_n, 3'b001);
        check("noto_flag", ack_timeout, 1'b0);
`endif
        x = cyc;
        stage_ack = 3'b001;
        s1 = x + SG + 2;
        s2 = s1 + SG + 1;
        dn = s2 + 1;
        push_evt("s1_late", s1, 3'b011, 1'b0, tmo, llc);
        push_evt("s2_late", s2, 3'b111, 1'b0, tmo, llc);
        push_evt("done_late", dn, 3'b111, 1'b1, tmo, llc);
        to_cyc(dn + 2);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        check("sb_empty", sb_q.size(), 0);

        // Asynchronous reset clears everything without a clock edge.
        mon_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stage", stage_rst_n, 3'b000);
        check("arst_done", seq_done, 1'b0);
        check("arst_llc", lock_loss_cnt, 8'd0);
        check("arst_tmo", ack_timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
